aes_inv_round_ctrl: RTL and testbench
=====================================

# aes_inv_round_ctrl

Round sequencer for the AES inverse cipher. It accepts one 128-bit ciphertext block, performs the initial and per-round AddRoundKey itself, and time-shares a single external inverse-stage bus among InvShiftRows, InvSubBytes and InvMixColumns. It sits between the block-level input/output handshake and the inverse stage units, and emits the finished plaintext. Stage traffic uses the 132-bit packet format: header [131:128] plus data [127:0].

## Interface
Parameters:
- NUM_ROUNDS, 10, number of cipher rounds; legal values are 10, 12 and 14.
- CHECK_HDR, 1, when 1, header mismatches on returned stage packets are flagged.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  ciphertext block offered.
- in_ready  out  1  controller idle and able to accept a block.
- in_data  in  128  ciphertext block.
- key_idx  out  4  round-key index requested.
- key_data  in  128  round key for key_idx; combinational, valid in the same cycle.
- stg_en  out  1  one-cycle issue strobe to the stage bus.
- stg_sel  out  2  stage select: 00 InvShiftRows, 01 InvSubBytes, 10 InvMixColumns; 11 is reserved and never driven.
- stg_data  out  132  packet issued to the stage: {round header, state}.
- stg_result  in  132  stage result packet; valid exactly 1 cycle after stg_en.
- out_valid  out  1  plaintext available.
- out_ready  in  1  consumer accepts the plaintext.
- out_data  out  128  plaintext.
- out_err  out  1  qualifies out_valid; header check failed.
- busy  out  1  high when the FSM is not in IDLE.

## Operation
- FSM states: IDLE, ARK, ISSUE, WAIT, DONE.
- Registers:
  - state: 128-bit working state.
  - rnd: 4-bit round counter, 0..NUM_ROUNDS.
  - op: 2-bit step within the round (ISR, ISB, ARK, IMC).
  - err: 1-bit error flag.
- IDLE:
  - in_ready=1.
  - On in_valid: load state<=in_data, set rnd<=0, clear err, go to ARK.
- ARK:
  - Drive key_idx = NUM_ROUNDS - rnd.
  - Update state <= state ^ key_data.
  - Next state:
    - if rnd==0: rnd<=1, op<=ISR, go to ISSUE.
    - else if rnd<NUM_ROUNDS: op<=IMC, go to ISSUE.
    - else (final round): go to DONE.
- ISSUE:
  - stg_en=1, stg_sel=op, stg_data={rnd[3:0], state}; go to WAIT.
- WAIT:
  - Capture state<=stg_result[127:0].
  - If CHECK_HDR and stg_result[131:128] != rnd, set err<=1 and go to DONE with no further operations.
  - Otherwise advance:
    - ISR → op=ISB, go to ISSUE.
    - ISB → go to ARK.
    - IMC → rnd<=rnd+1, op=ISR, go to ISSUE.
- InvMixColumns is never issued in the final round. Its header-10 pass-through is therefore never exercised by this block.
- DONE:
  - out_valid=1, out_data=state, out_err=err.
  - Holds all outputs stable until out_ready; then go to IDLE.
  - in_ready stays 0 in DONE, so a new block is accepted one cycle after the output handshake at the earliest.
- stg_data, stg_sel and key_idx are 0 whenever their owning state is inactive. stg_en=0 outside ISSUE.
- in_data is ignored when in_ready=0.

## Timing
- Reset values: FSM=IDLE; state=0; rnd=0; op=0; err=0; in_ready=1; out_valid=0; out_err=0; busy=0; stg_en=0; stg_sel=0; stg_data=0; key_idx=0; out_data=0.
- Reset asserted mid-block abandons the block immediately. No output is produced, and any stage result in flight is ignored.
- Accept in cycle T (in_valid & in_ready). Then:
  - ARK occupies cycle T+1.
  - Each non-final round takes 7 cycles (ISSUE/WAIT ×3 plus ARK).
  - The final round takes 5 cycles.
  - out_valid rises in cycle T + 7·NUM_ROUNDS, i.e. T+70 for NUM_ROUNDS=10.
- A header error shortens latency: DONE follows the failing WAIT cycle directly.
- Throughput: one block per 7·NUM_ROUNDS+1 cycles when out_ready is held high.

## Structure
- Shared package aes_pkg holds:
  - state_t enum {IDLE, ARK, ISSUE, WAIT, DONE}.
  - stage_sel_t {SEL_ISR=2'b00, SEL_ISB=2'b01, SEL_IMC=2'b10}.
  - HDR_W=4 and PKT_W=132.
- No sub-module: the FSM, counters and the XOR for AddRoundKey live in one module.

## Test plan
- Reset, then idle: all outputs equal their reset values; in_ready=1.
- FIPS-197 C.1 vector:
  - ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
  - key 000102030405060708090a0b0c0d0e0f, with the bench key ROM and bench stage models.
  - Required: out_data=00112233445566778899aabbccddeeff, out_err=0, out_valid first high in cycle T+70, and exactly 29 stg_en pulses, none with sel=10 while rnd=10.
- Backpressure: hold out_ready=0 for 20 cycles. out_data and out_valid stay stable and in_ready=0. Raise out_ready: in_ready=1 on the next cycle.
- Header fault: the stage model returns header 0 on round 3 InvSubBytes. Required: out_valid the cycle after that WAIT, and out_err=1.
- Reset mid-block: assert rst at cycle T+30. Required: immediate return to the reset values, and no out_valid afterward. A fresh block then completes normally.
- Back-to-back: in_valid held high with two blocks and out_ready=1. Required: the second block is accepted exactly 71 cycles after the first, and both outputs are correct.

Source files
------------

// File: rtl/aes_inv_round_ctrl_pkg.sv
// Shared types and packet geometry for the AES inverse-cipher round controller.
package aes_pkg;

  localparam int HDR_W = 4;
  localparam int BLK_W = 128;
  localparam int PKT_W = HDR_W + BLK_W;

  typedef enum logic [2:0] {
    IDLE,
    ARK,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    SEL_ISR = 2'b00,
    SEL_ISB = 2'b01,
    SEL_IMC = 2'b10
  } stage_sel_t;

endpackage

// File: rtl/aes_inv_round_ctrl_if.sv
// Block handshake, round-key lookup and inverse-stage bus of the round controller.
interface aes_inv_round_ctrl_if;
  import aes_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [BLK_W-1:0] in_data;
  logic [HDR_W-1:0] key_idx;
  logic [BLK_W-1:0] key_data;
  logic             stg_en;
  logic [1:0]       stg_sel;
  logic [PKT_W-1:0] stg_data;
  logic [PKT_W-1:0] stg_result;
  logic             out_valid;
  logic             out_ready;
  logic [BLK_W-1:0] out_data;
  logic             out_err;
  logic             busy;

  modport master (
    input  in_valid, in_data, key_data, stg_result, out_ready,
    output in_ready, key_idx, stg_en, stg_sel, stg_data,
           out_valid, out_data, out_err, busy
  );

  modport slave (
    output in_valid, in_data, key_data, stg_result, out_ready,
    input  in_ready, key_idx, stg_en, stg_sel, stg_data,
           out_valid, out_data, out_err, busy
  );

endinterface

// File: rtl/aes_inv_round_ctrl.sv
// AES inverse-cipher round sequencer: does AddRoundKey locally and time-shares
// one external stage bus among InvShiftRows, InvSubBytes and InvMixColumns.
module aes_inv_round_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10,
  parameter bit CHECK_HDR  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  aes_inv_round_ctrl_if.master bus
);

  localparam logic [HDR_W-1:0] NR = HDR_W'(NUM_ROUNDS);

  state_t           fsm_q, fsm_d;
  logic [BLK_W-1:0] state_q, state_d;
  logic [HDR_W-1:0] rnd_q, rnd_d;
  stage_sel_t       op_q, op_d;
  logic             err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rnd_q   <= '0;
      op_q    <= SEL_ISR;
      err_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rnd_q   <= rnd_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rnd_d   = rnd_q;
    op_d    = op_q;
    err_d   = err_q;
    unique case (fsm_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = bus.in_data;
          rnd_d   = '0;
          err_d   = 1'b0;
          fsm_d   = ARK;
        end
      end
      ARK: begin
        state_d = state_q ^ bus.key_data;
        if (rnd_q == '0) begin
          rnd_d = 4'd1;
          op_d  = SEL_ISR;
          fsm_d = ISSUE;
        end else if (rnd_q < NR) begin
          op_d  = SEL_IMC;
          fsm_d = ISSUE;
        end else begin
          fsm_d = DONE;
        end
      end
      ISSUE: fsm_d = WAIT;
      WAIT: begin
        state_d = bus.stg_result[BLK_W-1:0];
        // A stale or misrouted result aborts the block; the bad data is still reported.
        if (CHECK_HDR && (bus.stg_result[PKT_W-1:BLK_W] != rnd_q)) begin
          err_d = 1'b1;
          fsm_d = DONE;
        end else begin
          unique case (op_q)
            SEL_ISR: begin
              op_d  = SEL_ISB;
              fsm_d = ISSUE;
            end
            SEL_ISB: fsm_d = ARK;
            SEL_IMC: begin
              rnd_d = rnd_q + 4'd1;
              op_d  = SEL_ISR;
              fsm_d = ISSUE;
            end
            default: begin
              err_d = 1'b1;
              fsm_d = DONE;
            end
          endcase
        end
      end
      DONE: begin
        if (bus.out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.key_idx   = '0;
    bus.stg_en    = 1'b0;
    bus.stg_sel   = 2'b00;
    bus.stg_data  = '0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_err   = 1'b0;
    bus.busy      = (fsm_q != IDLE);
    unique case (fsm_q)
      IDLE:  bus.in_ready = 1'b1;
      ARK:   bus.key_idx  = NR - rnd_q;
      ISSUE: begin
        bus.stg_en   = 1'b1;
        bus.stg_sel  = op_q;
        bus.stg_data = {rnd_q, state_q};
      end
      DONE: begin
        bus.out_valid = 1'b1;
        bus.out_data  = state_q;
        bus.out_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Bench for aes_inv_round_ctrl: software AES model provides the key ROM, the
// inverse stage units and the expected plaintext (via forward encryption).
module tb_aes_inv_round_ctrl;
  import aes_pkg::*;

  localparam int NR = 10;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

  logic clk = 1'b0;
  logic rst = 1'b1;
  aes_inv_round_ctrl_if bus();

  aes_inv_round_ctrl #(.NUM_ROUNDS(NR), .CHECK_HDR(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int en_cnt = 0;
  int sel_bad = 0;
  bit fault_on = 1'b0;
  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [127:0] rk [0:NR];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [131:0] got, input logic [131:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- AES reference arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
  endtask

  // Byte k of a block sits at bits [127-8k -: 8]; row = k%4, column = k/4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (inv) o[127-8*(r+4*((c+r)%4)) -: 8] = s[127-8*(r+4*c) -: 8];
        else     o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++)
      o[127-8*k -: 8] = inv ? isbox[s[127-8*k -: 8]] : sbox[s[127-8*k -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    logic [7:0] m [4];
    logic [7:0] a [4];
    o = '0;
    if (inv) begin m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09; end
    else     begin m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01; end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-8*(r+4*c) -: 8];
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = gmul(m[0], a[r]) ^ gmul(m[1], a[(r+1)%4])
                               ^ gmul(m[2], a[(r+2)%4]) ^ gmul(m[3], a[(r+3)%4]);
    end
    return o;
  endfunction

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [0:4*NR+3];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 4*NR+4; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k <= NR; k++) rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk[0];
    for (int r = 1; r <= NR; r++) begin
      s = shift_rows(sub_bytes(s, 1'b0), 1'b0);
      if (r < NR) s = mix_columns(s, 1'b0);
      s ^= rk[r];
    end
    return s;
  endfunction

  // Decryption state right after InvSubBytes of round stop_rnd.
  function automatic logic [127:0] partial_dec(input logic [127:0] ct, input int stop_rnd);
    logic [127:0] s;
    s = ct ^ rk[NR];
    for (int r = 1; r <= NR; r++) begin
      s = sub_bytes(shift_rows(s, 1'b1), 1'b1);
      if (r == stop_rnd) return s;
      s = mix_columns(s ^ rk[NR-r], 1'b1);
    end
    return s;
  endfunction

  function automatic logic [131:0] stage_model(input logic [1:0] sel, input logic [131:0] pkt);
    logic [127:0] d;
    logic [3:0]   h;
    h = pkt[131:128];
    case (sel)
      2'b00:   d = shift_rows(pkt[127:0], 1'b1);
      2'b01:   d = sub_bytes(pkt[127:0], 1'b1);
      default: d = mix_columns(pkt[127:0], 1'b1);
    endcase
    if (fault_on && sel == 2'b01 && h == 4'd3) h = 4'd0;
    return {h, d};
  endfunction

  // ---------------- environment models ----------------
  assign bus.key_data = (int'(bus.key_idx) <= NR) ? rk[bus.key_idx] : '0;

  always @(posedge clk) begin
    if (bus.stg_en) begin
      en_cnt <= en_cnt + 1;
      if (bus.stg_sel == 2'b11 || (bus.stg_sel == 2'b10 && bus.stg_data[131:128] == 4'(NR)))
        sel_bad <= sel_bad + 1;
      bus.stg_result <= stage_model(bus.stg_sel, bus.stg_data);
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"},  bus.in_ready, 1);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_err"},   bus.out_err, 0);
    chk({tag, "_busy"},      bus.busy, 0);
    chk({tag, "_stg_en"},    bus.stg_en, 0);
    chk({tag, "_stg_sel"},   bus.stg_sel, 0);
    chk({tag, "_stg_data"},  bus.stg_data, 0);
    chk({tag, "_key_idx"},   bus.key_idx, 0);
    chk({tag, "_out_data"},  bus.out_data, 0);
  endtask

  // Called at a negedge with the DUT idle; returns one negedge after out_valid is seen.
  task automatic run_block(input string tag, input logic [127:0] ct, input logic [127:0] exp_d,
                           input bit exp_e, input int exp_lat);
    int  t0;
    bit  seen;
    bus.in_valid = 1'b1;
    bus.in_data  = ct;
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    t0   = cyc;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
      if (bus.out_valid) begin
        seen = 1'b1;
        chk({tag, "_latency"}, cyc - t0, exp_lat);
        chk({tag, "_data"}, bus.out_data, exp_d);
        chk({tag, "_err"}, bus.out_err, exp_e);
      end
    end
    if (!seen) chk({tag, "_timeout"}, 0, 1);
    @(negedge clk);
  endtask

  logic [127:0] pt, ct, pt2, ct2;
  logic [127:0] got [2];
  int           tacc [2];
  int           e0, b0, acc, outs, nval;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    build_sbox();
    expand(FIPS_KEY);
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst = 1'b0;
    @(negedge clk);
    check_reset("idle");

    e0 = en_cnt;
    b0 = sel_bad;
    run_block("fips", FIPS_CT, FIPS_PT, 1'b0, 7*NR);
    chk("fips_stg_en_count", en_cnt - e0, 29);
    chk("fips_bad_sel", sel_bad - b0, 0);

    for (int n = 0; n < 4; n++) begin
      expand({$urandom, $urandom, $urandom, $urandom});
      pt = {$urandom, $urandom, $urandom, $urandom};
      run_block("rand", encrypt(pt), pt, 1'b0, 7*NR);
    end

    // Backpressure on the output side.
    pt = {$urandom, $urandom, $urandom, $urandom};
    bus.out_ready = 1'b0;
    run_block("bp", encrypt(pt), pt, 1'b0, 7*NR);
    for (int i = 0; i < 20; i++) begin
      chk("bp_hold_valid", bus.out_valid, 1);
      chk("bp_hold_data", bus.out_data, pt);
      chk("bp_hold_in_ready", bus.in_ready, 0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", bus.in_ready, 1);
    chk("bp_release_valid", bus.out_valid, 0);

    // Header fault on round 3 InvSubBytes.
    pt = {$urandom, $urandom, $urandom, $urandom};
    ct = encrypt(pt);
    fault_on = 1'b1;
    run_block("hdr", ct, partial_dec(ct, 3), 1'b1, 20);
    fault_on = 1'b0;

    // Reset in the middle of a block.
    pt = {$urandom, $urandom, $urandom, $urandom};
    bus.in_valid = 1'b1;
    bus.in_data  = encrypt(pt);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (29) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset("midrst");
    @(negedge clk);
    rst = 1'b0;
    nval = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.out_valid) nval++;
    end
    chk("midrst_no_output", nval, 0);
    run_block("post_rst", encrypt(pt), pt, 1'b0, 7*NR);

    // Back-to-back blocks with in_valid held high.
    pt  = {$urandom, $urandom, $urandom, $urandom};
    pt2 = {$urandom, $urandom, $urandom, $urandom};
    ct  = encrypt(pt);
    ct2 = encrypt(pt2);
    acc  = 0;
    outs = 0;
    for (int i = 0; i < 400 && outs < 2; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        got[outs] = bus.out_data;
        chk("b2b_err", bus.out_err, 0);
        outs++;
      end
      if (acc < 2) begin
        bus.in_valid = 1'b1;
        bus.in_data  = (acc == 0) ? ct : ct2;
      end else begin
        bus.in_valid = 1'b0;
      end
      if (bus.in_ready && bus.in_valid) begin
        tacc[acc] = cyc;
        acc++;
      end
    end
    bus.in_valid = 1'b0;
    chk("b2b_accepts", acc, 2);
    chk("b2b_outputs", outs, 2);
    if (acc == 2) chk("b2b_spacing", tacc[1] - tacc[0], 7*NR + 1);
    if (outs == 2) begin
      chk("b2b_data0", got[0], pt);
      chk("b2b_data1", got[1], pt2);
    end

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", n_chk);
    $fatal(1);
  end

endmodule
